lsu_bus_adapter: RTL

- Load/store unit sitting directly downstream of the single-cycle core's ALU/data-memory port.
- Converts a core memory request (address from ALU result, store data from rs2, width/sign from funct3) into a word-aligned valid/ready bus transaction with byte enables.
- Returns sign/zero-extended load data for write-back.
- Holds the core via stall while the multi-cycle bus access is outstanding.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_bus_adapter_if.sv | 21 ++
 rtl/lsu_data_align.sv | 60 ++++++
 rtl/lsu_bus_adapter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store bus adapter.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_bus_adapter_if.sv
// Word-aligned valid/ready memory bus between the LSU (master) and memory (slave).
interface lsu_bus_adapter_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rdata
  );
endinterface

// File: rtl/lsu_data_align.sv
// Combinational lane logic: store byte enables/replication/legality and load lane extraction.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic        i_st_write,
  input  logic [2:0]  i_st_f3,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  output logic        o_illegal,
  input  logic [2:0]  i_ld_f3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_lane;

  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;
    case (i_st_f3)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_st_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        o_be         = 4'b0011 << i_st_addr_lo;
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_st_addr_lo[0];
      end
      F3_W: begin
        o_be         = 4'b1111;
        o_misaligned = |i_st_addr_lo;
      end
      default: o_illegal = 1'b1;
    endcase
    // Unsigned variants exist only for loads.
    if (i_st_write && (i_st_f3 == F3_BU || i_st_f3 == F3_HU))
      o_illegal = 1'b1;
  end

  assign w_lane = i_rdata >> {i_ld_addr_lo, 3'b000};

  always_comb begin
    o_rdata = i_rdata;
    case (i_ld_f3)
      F3_B:    o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_BU:   o_rdata = {24'd0, w_lane[7:0]};
      F3_H:    o_rdata = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_HU:   o_rdata = {16'd0, w_lane[15:0]};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Load/store unit: turns a core memory request into one valid/ready bus access and stalls the core until done.
module lsu_bus_adapter
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_write,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_stall,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  lsu_bus_adapter_if.master bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e    r_state;
  logic [TO_W-1:0] r_cnt;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [31:0]   r_rsp_rdata;
  logic          r_bus_req_valid;
  logic          r_bus_we;
  logic [31:0]   r_bus_addr;
  logic [3:0]    r_bus_be;
  logic [31:0]   r_bus_wdata;
  logic [2:0]    r_ld_f3;
  logic [1:0]    r_ld_lo;

  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_misaligned;
  logic          w_illegal;
  logic [31:0]   w_ld_rdata;

  lsu_data_align u_align (
    .i_st_write   (i_req_write),
    .i_st_f3      (i_req_funct3),
    .i_st_addr_lo (i_req_addr[1:0]),
    .i_wdata      (i_req_wdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal),
    .i_ld_f3      (r_ld_f3),
    .i_ld_addr_lo (r_ld_lo),
    .i_rdata      (bus.bus_rdata),
    .o_rdata      (w_ld_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_err       <= 1'b0;
      r_rsp_rdata     <= '0;
      r_bus_req_valid <= 1'b0;
      r_bus_we        <= 1'b0;
      r_bus_addr      <= '0;
      r_bus_be        <= '0;
      r_bus_wdata     <= '0;
      r_ld_f3         <= '0;
      r_ld_lo         <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            if (w_illegal || w_misaligned) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              r_state     <= DONE;
            end else begin
              r_bus_req_valid <= 1'b1;
              r_bus_we        <= i_req_write;
              r_bus_addr      <= {i_req_addr[31:2], 2'b00};
              r_bus_be        <= w_be;
              r_bus_wdata     <= w_wdata;
              r_ld_f3         <= i_req_funct3;
              r_ld_lo         <= i_req_addr[1:0];
              r_state         <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.bus_req_ready) begin
            r_bus_req_valid <= 1'b0;
            r_cnt           <= '0;
            r_state         <= WAIT;
          end
        end
        WAIT: begin
          // A response on the final timeout cycle still completes cleanly.
          if (bus.bus_rsp_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_bus_we ? 32'd0 : w_ld_rdata;
            r_state     <= DONE;
          end else if (r_cnt == TO_LAST) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The issue-cycle stall must be combinational so the core holds PC on that very edge.
  assign o_stall = (r_state == IDLE) ? i_req_valid
                                     : (r_state == REQ || r_state == WAIT);

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = r_rsp_rdata;

  assign bus.bus_req_valid = r_bus_req_valid;
  assign bus.bus_we        = r_bus_we;
  assign bus.bus_addr      = r_bus_addr;
  assign bus.bus_be        = r_bus_be;
  assign bus.bus_wdata     = r_bus_wdata;

endmodule
